idma_tpram_fifo_ctrl: RTL and testbench

//   Single-clock FIFO controller that owns both ports of a 64x144 two-port SRAM macro
//   (active-low chip enables, 1-cycle registered read). It accepts words on a valid/ready

---
 rtl/idma_tpram_fifo_ctrl.sv | 137 +++++++++++++
 tb/tb_idma_tpram_fifo_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_tpram_fifo_ctrl.sv
// idma_tpram_fifo_ctrl
//   Single-clock FIFO controller that owns both ports of a two-port SRAM macro.
//   Words are written into the SRAM from a valid/ready push side. A two-entry
//   output buffer is prefetched from the SRAM, which has a one-cycle read latency,
//   so the pop side can sustain one word per cycle.
//
//   Ports
//     clk, rst_n              clock, asynchronous active-low reset
//     in_valid/in_ready/in_data     push handshake and data
//     out_valid/out_ready/out_data  pop handshake and head-of-buffer data
//     count                   words held: SRAM + read in flight + output buffer
//     ram_wceb/waddr/wdata    SRAM write port (active-low enable)
//     ram_rceb/raddr/rdata    SRAM read port (active-low enable, data next cycle)
module idma_tpram_fifo_ctrl #(
   parameter int DW    = 144,
   parameter int AW    = 6,
   parameter int DEPTH = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [AW+1:0] count,
   output logic          ram_wceb,
   output logic [AW-1:0] ram_waddr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_rceb,
   output logic [AW-1:0] ram_raddr,
   input  logic [DW-1:0] ram_rdata
);

   localparam logic [AW:0] RAM_FULL = (AW+1)'(DEPTH);

   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   ram_cnt_q, ram_cnt_d;
   logic          rd_pend_q, rd_pend_d;
   logic [1:0]    ob_cnt_q, ob_cnt_d;
   logic          ob_head_q, ob_head_d;
   logic [DW-1:0] ob_mem_q [2];
   logic [DW-1:0] ob_mem_d [2];
   logic [AW+1:0] count_q, count_d;

   logic          in_fire;
   logic          out_fire;
   logic          rd_issue;
   logic [2:0]    ob_occ;
   logic          ob_wr_idx;

   always_comb begin
      in_ready  = (ram_cnt_q != RAM_FULL);
      in_fire   = in_valid & in_ready;
      out_valid = (ob_cnt_q != 2'd0);
      out_fire  = out_valid & out_ready;

      // Buffer slots already committed (filled or with a read in flight).
      // A pop this cycle frees one slot, so one more committed slot is allowed.
      ob_occ   = {1'b0, ob_cnt_q} + {2'b00, rd_pend_q};
      rd_issue = (ram_cnt_q != '0) &&
                 (out_fire ? (ob_occ < 3'd3) : (ob_occ < 3'd2));

      ram_wceb  = ~in_fire;
      ram_waddr = wptr_q;
      ram_wdata = in_data;
      ram_rceb  = ~rd_issue;
      ram_raddr = rptr_q;

      out_data  = out_valid ? ob_mem_q[ob_head_q] : '0;
      count     = count_q;

      wptr_d    = in_fire  ? wptr_q + AW'(1) : wptr_q;
      rptr_d    = rd_issue ? rptr_q + AW'(1) : rptr_q;
      rd_pend_d = rd_issue;

      ram_cnt_d = ram_cnt_q;
      case ({in_fire, rd_issue})
         2'b10:   ram_cnt_d = ram_cnt_q + (AW+1)'(1);
         2'b01:   ram_cnt_d = ram_cnt_q - (AW+1)'(1);
         default: ram_cnt_d = ram_cnt_q;
      endcase

      // Fill slot is head+cnt (mod 2). When the buffer is full and popping in
      // the same cycle as a fill, this lands on the slot being vacated.
      ob_wr_idx = ob_head_q ^ ob_cnt_q[0];
      ob_mem_d  = ob_mem_q;
      if (rd_pend_q) ob_mem_d[ob_wr_idx] = ram_rdata;

      ob_head_d = out_fire ? ~ob_head_q : ob_head_q;

      ob_cnt_d = ob_cnt_q;
      case ({rd_pend_q, out_fire})
         2'b10:   ob_cnt_d = ob_cnt_q + 2'd1;
         2'b01:   ob_cnt_d = ob_cnt_q - 2'd1;
         default: ob_cnt_d = ob_cnt_q;
      endcase

      count_d = (AW+2)'(ram_cnt_d) + (AW+2)'(rd_pend_d) + (AW+2)'(ob_cnt_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         ram_cnt_q   <= '0;
         rd_pend_q   <= 1'b0;
         ob_cnt_q    <= 2'd0;
         ob_head_q   <= 1'b0;
         ob_mem_q[0] <= '0;
         ob_mem_q[1] <= '0;
         count_q     <= '0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         ram_cnt_q   <= ram_cnt_d;
         rd_pend_q   <= rd_pend_d;
         ob_cnt_q    <= ob_cnt_d;
         ob_head_q   <= ob_head_d;
         ob_mem_q[0] <= ob_mem_d[0];
         ob_mem_q[1] <= ob_mem_d[1];
         count_q     <= count_d;
      end
   end

   // The issue rule keeps the output buffer from ever taking a third word.
   a_ob_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(rd_pend_q && !out_fire && (ob_cnt_q == 2'd2)));

   // Equal pointers mean the SRAM is empty or full, so a read and a write
   // can never both be enabled on the same address.
   a_no_addr_collision : assert property (@(posedge clk) disable iff (!rst_n)
      !(in_fire && rd_issue && (wptr_q == rptr_q)));

endmodule

// File: tb/tb_idma_tpram_fifo_ctrl.sv
module tb_idma_tpram_fifo_ctrl;

   localparam int DW    = 144;
   localparam int AW    = 6;
   localparam int DEPTH = 64;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [AW+1:0] count;
   logic          ram_wceb;
   logic [AW-1:0] ram_waddr;
   logic [DW-1:0] ram_wdata;
   logic          ram_rceb;
   logic [AW-1:0] ram_raddr;
   logic [DW-1:0] ram_rdata;

   idma_tpram_fifo_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count),
      .ram_wceb  (ram_wceb),
      .ram_waddr (ram_waddr),
      .ram_wdata (ram_wdata),
      .ram_rceb  (ram_rceb),
      .ram_raddr (ram_raddr),
      .ram_rdata (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM macro: registered read, output held when not reading.
   logic [DW-1:0] sram [DEPTH];
   always @(posedge clk) begin
      if (!ram_wceb) sram[ram_waddr] <= ram_wdata;
      if (!ram_rceb) ram_rdata <= sram[ram_raddr];
   end

   int total;
   int bad;

   // Reference model: where each word lives, as plain queues.
   logic [DW-1:0] m_ram [$];
   logic [DW-1:0] m_ob  [$];
   int            m_pend;
   logic [DW-1:0] m_pend_word;
   int            m_wp;
   int            m_rp;
   int            n_push;
   int            n_pop;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      w = '0;
      for (int i = 0; i < DW/16; i++) w[i*16 +: 16] = 16'($urandom);
      return w;
   endfunction

   function automatic void model_clear();
      m_ram.delete();
      m_ob.delete();
      m_pend = 0;
      m_pend_word = '0;
      m_wp = 0;
      m_rp = 0;
   endfunction

   function automatic int model_count();
      return m_ram.size() + m_pend + m_ob.size();
   endfunction

   // One clock cycle: drive, compare every output against the model, advance model.
   task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy);
      logic          e_rdy, e_ov, fin, fout, e_iss;
      logic [DW-1:0] e_od;
      int            e_cnt;
      @(negedge clk);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      #1;
      e_rdy = (m_ram.size() != DEPTH);
      e_cnt = model_count();
      e_ov  = (m_ob.size() != 0);
      e_od  = e_ov ? m_ob[0] : '0;
      fin   = iv && e_rdy;
      fout  = e_ov && ordy;
      e_iss = (m_ram.size() != 0) && ((m_ob.size() + m_pend - (fout ? 1 : 0)) < 2);

      chk("in_ready",  DW'(in_ready),  DW'(e_rdy));
      chk("out_valid", DW'(out_valid), DW'(e_ov));
      chk("out_data",  out_data,       e_od);
      chk("count",     DW'(count),     DW'(e_cnt));
      chk("ram_wceb",  DW'(ram_wceb),  DW'(!fin));
      chk("ram_rceb",  DW'(ram_rceb),  DW'(!e_iss));
      if (fin) begin
         chk("ram_waddr", DW'(ram_waddr), DW'(m_wp));
         chk("ram_wdata", ram_wdata,      id);
      end
      if (e_iss) chk("ram_raddr", DW'(ram_raddr), DW'(m_rp));
      chk("addr_collision", DW'(ram_wceb | ram_rceb | (ram_waddr != ram_raddr)), DW'(1'b1));

      if (fout) begin
         void'(m_ob.pop_front());
         n_pop++;
      end
      if (m_pend != 0) m_ob.push_back(m_pend_word);
      if (e_iss) begin
         m_pend_word = m_ram.pop_front();
         m_pend = 1;
         m_rp = (m_rp + 1) % DEPTH;
      end else begin
         m_pend = 0;
      end
      if (fin) begin
         m_ram.push_back(id);
         m_wp = (m_wp + 1) % DEPTH;
         n_push++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("rst_in_ready",  DW'(in_ready),  DW'(1'b1));
      chk("rst_out_valid", DW'(out_valid), DW'(1'b0));
      chk("rst_count",     DW'(count),     DW'(0));
      chk("rst_ram_wceb",  DW'(ram_wceb),  DW'(1'b1));
      chk("rst_ram_rceb",  DW'(ram_rceb),  DW'(1'b1));
      chk("rst_out_data",  out_data,       '0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int acc;
   int streamed;
   int pushed;
   int cyc;
   logic [DW-1:0] w;

   initial begin
      total = 0;
      bad = 0;
      n_push = 0;
      n_pop = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_data = '0;
      model_clear();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      do_reset();

      // Single word latency and count trace.
      w = DW'(20'h1234);
      step(1'b1, w, 1'b1);
      chk("t0_count", DW'(count), DW'(0));
      step(1'b0, '0, 1'b1);
      chk("t1_count", DW'(count), DW'(1));
      chk("t1_valid", DW'(out_valid), DW'(1'b0));
      step(1'b0, '0, 1'b1);
      chk("t2_count", DW'(count), DW'(1));
      chk("t2_valid", DW'(out_valid), DW'(1'b0));
      step(1'b0, '0, 1'b1);
      chk("t3_count", DW'(count), DW'(1));
      chk("t3_valid", DW'(out_valid), DW'(1'b1));
      chk("t3_data",  out_data, DW'(20'h1234));
      step(1'b0, '0, 1'b1);
      chk("t4_count", DW'(count), DW'(0));
      chk("t4_valid", DW'(out_valid), DW'(1'b0));

      // Fill with pops blocked: 66 of 70 offered words are taken.
      acc = 0;
      for (int i = 0; i < 70; i++) begin
         step(1'b1, rand_word(), 1'b0);
         if (in_ready) acc++;
      end
      chk("fill_accepted", DW'(acc), DW'(66));
      step(1'b1, rand_word(), 1'b0);
      chk("full_count",    DW'(count),    DW'(66));
      chk("full_in_ready", DW'(in_ready), DW'(1'b0));
      chk("full_wceb",     DW'(ram_wceb), DW'(1'b1));

      // Pop while full: no push that cycle, a read issues, space next cycle.
      step(1'b1, rand_word(), 1'b1);
      chk("fullpop_in_ready", DW'(in_ready), DW'(1'b0));
      chk("fullpop_wceb",     DW'(ram_wceb), DW'(1'b1));
      chk("fullpop_rceb",     DW'(ram_rceb), DW'(1'b0));
      step(1'b0, '0, 1'b0);
      chk("afterpop_in_ready", DW'(in_ready), DW'(1'b1));
      chk("afterpop_count",    DW'(count),    DW'(65));

      // Reset with data in flight and a nearly full SRAM.
      step(1'b1, rand_word(), 1'b1);
      do_reset();

      // Streaming: one word per cycle after the 3-cycle fill.
      n_pop = 0;
      streamed = 0;
      for (int i = 0; i < 300; i++) begin
         step(1'b1, rand_word(), 1'b1);
         if (i >= 3 && out_valid) streamed++;
      end
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
      chk("stream_valid_cycles", DW'(streamed), DW'(297));
      chk("stream_popped",       DW'(n_pop),    DW'(300));
      chk("stream_empty",        DW'(count),    DW'(0));

      // Random handshakes.
      pushed = n_push;
      n_pop = 0;
      cyc = 0;
      while ((n_push - pushed) < 2000 && cyc < 20000) begin
         step(1'($urandom_range(0, 1)), rand_word(), 1'($urandom_range(0, 1)));
         cyc++;
      end
      chk("rand_pushed", DW'(n_push - pushed), DW'(2000));
      cyc = 0;
      while (model_count() != 0 && cyc < 200) begin
         step(1'b0, '0, 1'b1);
         cyc++;
      end
      step(1'b0, '0, 1'b1);
      chk("rand_popped",   DW'(n_pop),     DW'(2000));
      chk("rand_drained",  DW'(count),     DW'(0));
      chk("rand_no_valid", DW'(out_valid), DW'(1'b0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
